// File: rtl/lc4_pkg.sv
// Shared LC4 definitions: NZP bit positions, reset value and the branch-resolve FSM states.
package lc4_pkg;
    localparam int N_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int P_BIT = 0;
    localparam logic [2:0] NZP_RESET = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } br_state_e;
endpackage

// File: rtl/lc4_nzp_ctrl_if.sv
// Decode / writeback / redirect bundle for the NZP controller.
interface lc4_nzp_ctrl_if #(parameter int CNT_W = 2);
    logic             set_valid;
    logic             set_ready;
    logic             wb_valid;
    logic [15:0]      wb_value;
    logic             br_valid;
    logic [2:0]       br_cond;
    logic             br_ready;
    logic             res_valid;
    logic             res_taken;
    logic             flush;
    logic [2:0]       nzp;
    logic [CNT_W-1:0] pending;
    logic             err_underflow;

    modport master (
        output set_valid, wb_valid, wb_value, br_valid, br_cond, flush,
        input  set_ready, br_ready, res_valid, res_taken, nzp, pending, err_underflow
    );

    modport slave (
        input  set_valid, wb_valid, wb_value, br_valid, br_cond, flush,
        output set_ready, br_ready, res_valid, res_taken, nzp, pending, err_underflow
    );
endinterface

// File: rtl/lc4_nzp.sv
// Combinational NZP reducer: classifies a 16-bit two's-complement value as negative, zero or positive.
module lc4_nzp
    import lc4_pkg::*;
(
    input  logic [15:0] value,
    output logic [2:0]  nzp
);
    always_comb begin
        nzp = '0;
        if (value[15])
            nzp[N_BIT] = 1'b1;
        else if (value == 16'h0000)
            nzp[Z_BIT] = 1'b1;
        else
            nzp[P_BIT] = 1'b1;
    end
endmodule

// File: rtl/lc4_nzp_ctrl.sv
// NZP register sequencer: scoreboards in-flight NZP writers and holds each BR until its older writers retire.
module lc4_nzp_ctrl
    import lc4_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    lc4_nzp_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    br_state_e        state;
    logic [2:0]       nzp_q;
    logic [2:0]       cond_q;
    logic [CNT_W-1:0] pending_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] pend_next;
    logic             res_valid_q;
    logic             res_taken_q;
    logic             err_q;
    logic             set_fire;
    logic             wb_ok;
    logic [2:0]       wb_nzp;

    lc4_nzp u_reduce (
        .value (bus.wb_value),
        .nzp   (wb_nzp)
    );

    // No writeback bypass into set_ready: issue sees only registered occupancy.
    assign set_fire  = bus.set_valid & (pending_q != MAX_CNT);
    assign wb_ok     = bus.wb_valid & (pending_q != '0);
    assign pend_next = pending_q + CNT_W'(set_fire) - CNT_W'(wb_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            nzp_q       <= NZP_RESET;
            cond_q      <= '0;
            pending_q   <= '0;
            wait_cnt    <= '0;
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (bus.flush) begin
            state       <= IDLE;
            pending_q   <= '0;
            wait_cnt    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            pending_q   <= pend_next;
            res_valid_q <= 1'b0;
            if (wb_ok)
                nzp_q <= wb_nzp;
            if (bus.wb_valid && (pending_q == '0))
                err_q <= 1'b1;
            case (state)
                IDLE: begin
                    // A set issued alongside the BR counts as older than it.
                    if (bus.br_valid) begin
                        cond_q   <= bus.br_cond;
                        wait_cnt <= pend_next;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        res_taken_q <= |(cond_q & nzp_q);
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end else if (wb_ok) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.set_ready     = (pending_q != MAX_CNT);
    assign bus.br_ready      = (state == IDLE);
    assign bus.res_valid     = res_valid_q;
    assign bus.res_taken     = res_taken_q;
    assign bus.nzp           = nzp_q;
    assign bus.pending       = pending_q;
    assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_lc4_nzp_ctrl.sv
// Scoreboard bench for lc4_nzp_ctrl: a history-based reference predicts each BR outcome and its cycle.
module tb_lc4_nzp_ctrl;
    localparam int MAX   = 3;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lc4_nzp_ctrl_if #(.CNT_W(CNT_W)) bus ();

    lc4_nzp_ctrl #(.MAX_INFLIGHT(MAX), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit taken;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;

    // Reference state: writers issued/retired so far and the NZP value after each retirement.
    int         cyc = 0;
    int         issued = 0;
    int         retired = 0;
    logic [2:0] hist[$];
    bit         m_err = 0;
    bit         br_act = 0;
    bit         br_res = 0;
    int         br_need = 0;
    logic [2:0] br_c = '0;

    function automatic logic [2:0] nzp_of(logic [15:0] v);
        if ($signed(v) < 0)  return 3'b100;
        if ($signed(v) == 0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        int pend;
        bit sf;
        bit wo;
        if (!rst_n) begin
            cyc = 0; issued = 0; retired = 0; hist = {3'b010};
            m_err = 0; br_act = 0; br_res = 0;
        end else begin
            cyc++;
            pend = issued - retired;
            sf = bus.set_valid && (pend != MAX);
            wo = bus.wb_valid && (pend != 0);
            if (bus.flush) begin
                issued = retired;
                br_act = 0;
                br_res = 0;
            end else begin
                if (br_res) begin
                    br_act = 0;
                    br_res = 0;
                end else if (br_act) begin
                    if (retired >= br_need) begin
                        exp_q.push_back('{taken: |(br_c & hist[br_need]), cyc: cyc});
                        br_res = 1;
                    end
                end else if (bus.br_valid) begin
                    br_act  = 1;
                    br_c    = bus.br_cond;
                    br_need = issued + int'(sf);
                end
                if (sf) issued++;
                if (wo) begin
                    retired++;
                    hist.push_back(nzp_of(bus.wb_value));
                end
                if (bus.wb_valid && pend == 0) m_err = 1;
            end
        end
    end

    // Monitor: compares visible state every cycle and pops the scoreboard on each resolution.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pending", int'(bus.pending), issued - retired);
            chk("set_ready", int'(bus.set_ready), int'((issued - retired) != MAX));
            chk("br_ready", int'(bus.br_ready), int'(!br_act));
            chk("nzp", int'(bus.nzp), int'(hist[retired]));
            chk("err_underflow", int'(bus.err_underflow), int'(m_err));
            if (bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_res_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("res_cycle", cyc, e.cyc);
                    chk("res_taken", int'(bus.res_taken), int'(e.taken));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                chk("missing_res_valid", cyc, exp_q[0].cyc + 1000);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(bit sv, bit wv, logic [15:0] v, bit bv, logic [2:0] c, bit fl);
        bus.set_valid = sv;
        bus.wb_valid  = wv;
        bus.wb_value  = v;
        bus.br_valid  = bv;
        bus.br_cond   = c;
        bus.flush     = fl;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 16'h0, 0, 3'b000, 0);
    endtask

    initial begin
        logic [15:0] vals[6];
        vals = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h1234};
        bus.set_valid = 0; bus.wb_valid = 0; bus.wb_value = '0;
        bus.br_valid = 0; bus.br_cond = '0; bus.flush = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_nzp", int'(bus.nzp), 2);
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_br_ready", int'(bus.br_ready), 1);
        chk("rst_set_ready", int'(bus.set_ready), 1);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_err", int'(bus.err_underflow), 0);

        // Fast path
        drive(0, 0, 16'h0, 1, 3'b010, 0);
        idle(4);
        // Stall on two older writers, writebacks three cycles apart
        drive(1, 0, 16'h0, 0, 3'b000, 0);
        drive(1, 0, 16'h0, 0, 3'b000, 0);
        drive(0, 0, 16'h0, 1, 3'b100, 0);
        idle(1);
        drive(0, 1, 16'h0005, 0, 3'b000, 0);
        idle(2);
        drive(0, 1, 16'hFFFB, 0, 3'b000, 0);
        idle(4);
        chk("stall_nzp", int'(bus.nzp), 4);
        // Full, then simultaneous set + wb
        repeat (3) drive(1, 0, 16'h0, 0, 3'b000, 0);
        chk("full_set_ready", int'(bus.set_ready), 0);
        drive(1, 1, 16'h0000, 0, 3'b000, 0);
        chk("simul_pending", int'(bus.pending), 2);
        chk("simul_set_ready", int'(bus.set_ready), 1);
        repeat (2) drive(0, 1, 16'h0003, 0, 3'b000, 0);
        idle(2);
        // Younger set during WAIT is not waited on
        drive(1, 0, 16'h0, 0, 3'b000, 0);
        drive(0, 0, 16'h0, 1, 3'b010, 0);
        drive(1, 0, 16'h0, 0, 3'b000, 0);
        drive(0, 1, 16'h0000, 0, 3'b000, 0);
        idle(3);
        drive(0, 1, 16'h0009, 0, 3'b000, 0);
        idle(2);
        // Flush during WAIT, then an underflowing writeback
        drive(1, 0, 16'h0, 0, 3'b000, 0);
        drive(0, 0, 16'h0, 1, 3'b001, 0);
        idle(1);
        drive(0, 0, 16'h0, 0, 3'b000, 1);
        chk("flush_pending", int'(bus.pending), 0);
        chk("flush_br_ready", int'(bus.br_ready), 1);
        drive(0, 1, 16'h8000, 0, 3'b000, 0);
        chk("uflow_err", int'(bus.err_underflow), 1);
        chk("uflow_nzp", int'(bus.nzp), 1);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int  pend;
            bit  wv;
            pend = issued - retired;
            wv = (pend != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 1), wv, vals[$urandom_range(0, 5)] ^ 16'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 59) == 0);
        end
        idle(8);
        chk("drain_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
